// File: rtl/itrx_aib_phy_pkg.sv
// Shared types for the AIB PHY configuration sequencer: command opcodes,
// sequencer states and the APB address width.
package itrx_aib_phy_pkg;

  localparam int APB_AW = 12;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_POLL  = 2'd2,
    OP_DONE  = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_GAP,
    ST_RESP
  } seq_state_e;

endpackage

// File: rtl/itrx_aib_phy_apb_cfg_seq.sv
// APB master that executes one WRITE/READ/POLL/DONE command at a time against
// the AIB PHY register slave and raises a sticky conf_done.
module itrx_aib_phy_apb_cfg_seq
  import itrx_aib_phy_pkg::*;
#(
  parameter logic [31:0] POLL_MAX = 32'd255,
  parameter logic [31:0] POLL_GAP = 32'd15
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [APB_AW-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [31:0]       cmd_mask,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [APB_AW-1:0] paddr,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  input  logic              pready,
  output logic              conf_done
);

  seq_state_e  state;
  cmd_op_e     op_q;
  logic [31:0] wdata_q;
  logic [31:0] mask_q;
  logic [31:0] poll_cnt;
  logic [31:0] gap_cnt;
  logic [31:0] poll_cnt_nx;
  logic        match;

  assign cmd_ready   = (state == ST_IDLE) && !preset;
  assign poll_cnt_nx = (poll_cnt == 32'hFFFF_FFFF) ? poll_cnt : poll_cnt + 32'd1;
  assign match       = ((prdata ^ wdata_q) & mask_q) == 32'd0;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= ST_IDLE;
      op_q      <= OP_WRITE;
      wdata_q   <= 32'd0;
      mask_q    <= 32'd0;
      poll_cnt  <= 32'd0;
      gap_cnt   <= 32'd0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwdata    <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      conf_done <= 1'b0;
    end else begin
      // Response fields are single-cycle pulses; zero unless set below.
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      case (state)
        ST_IDLE: if (cmd_valid) begin
          op_q     <= cmd_op_e'(cmd_op);
          wdata_q  <= cmd_wdata;
          mask_q   <= cmd_mask;
          poll_cnt <= 32'd0;
          if (cmd_op_e'(cmd_op) == OP_DONE) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            conf_done <= 1'b1;
          end else begin
            state   <= ST_SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            paddr   <= cmd_addr;
            pwrite  <= (cmd_op_e'(cmd_op) == OP_WRITE);
            pwdata  <= (cmd_op_e'(cmd_op) == OP_WRITE) ? cmd_wdata : 32'd0;
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          penable <= 1'b1;
        end
        ST_ACCESS: if (pready) begin
          psel    <= 1'b0;
          penable <= 1'b0;
          if (op_q == OP_POLL) begin
            poll_cnt <= poll_cnt_nx;
            if (match || poll_cnt_nx == POLL_MAX) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= prdata;
              rsp_err   <= !match;
            end else if (POLL_GAP == 32'd0) begin
              state <= ST_SETUP;
              psel  <= 1'b1;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= 32'd0;
            end
          end else begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= (op_q == OP_READ) ? prdata : 32'd0;
          end
        end
        // APB stays idle for exactly POLL_GAP cycles between poll reads.
        ST_GAP: begin
          if (gap_cnt == POLL_GAP - 32'd1) begin
            state <= ST_SETUP;
            psel  <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
